ifetch_buf: RTL and testbench

Instruction prefetch buffer between the core's fetch stage and the instruction ROM. It autonomously issues sequential reads to the ROM, captures the returned words with their PCs in a small FIFO, and presents them to the decode stage over a valid/ready handshake. A redirect (branch, jump or trap) flushes all buffered and in-flight words and restarts fetching at the new PC.

---
 rtl/ifetch_buf_if.sv | 23 ++
 rtl/ifetch_buf.sv | 85 ++++++++
 tb/tb_ifetch_buf.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ifetch_buf_if.sv
// Fetch-buffer bus: ROM read port, redirect request and decode-side valid/ready stream.
// The master modport is the buffer itself; slave is the core/ROM environment.
interface ifetch_buf_if;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    modport master (
        output rom_en, rom_addr, inst_valid_o, inst_o, inst_pc_o,
        input  rom_inst, redirect_i, redirect_pc_i, inst_ready_i
    );

    modport slave (
        input  rom_en, rom_addr, inst_valid_o, inst_o, inst_pc_o,
        output rom_inst, redirect_i, redirect_pc_i, inst_ready_i
    );
endinterface

// File: rtl/ifetch_buf.sv
// Instruction prefetch buffer: credit-limited sequential ROM reads into a small {inst, pc} FIFO,
// flushed and restarted by a redirect.
module ifetch_buf #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst,
    ifetch_buf_if.master bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW+1:0] DepthW = (PtrW + 2)'(DEPTH);

    logic [31:0]     fetch_pc;
    logic [31:0]     inflight_pc;
    logic            inflight;
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW:0]   count;
    logic [31:0]     mem_inst [DEPTH];
    logic [31:0]     mem_pc   [DEPTH];

    logic [PtrW+1:0] credit;
    logic            issue;
    logic            push;
    logic            pop;
    logic            valid;

    // An outstanding read reserves a slot so its response can always be pushed.
    assign credit = {1'b0, count} + {{(PtrW + 1){1'b0}}, inflight};
    assign issue  = !rst && !bus.redirect_i && (credit < DepthW);
    assign valid  = (count != '0);
    assign push   = inflight && !bus.redirect_i;
    assign pop    = valid && bus.inst_ready_i && !bus.redirect_i;

    assign bus.rom_en       = issue;
    assign bus.rom_addr     = fetch_pc;
    assign bus.inst_valid_o = valid;
    assign bus.inst_o       = valid ? mem_inst[rd_ptr] : 32'h0;
    assign bus.inst_pc_o    = valid ? mem_pc[rd_ptr] : 32'h0;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_inst[wr_ptr] <= bus.rom_inst;
            mem_pc[wr_ptr]   <= inflight_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (bus.redirect_i) begin
            // The response for any read issued last cycle is dropped via inflight <= 0.
            fetch_pc <= {bus.redirect_pc_i[31:2], 2'b00};
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight    <= 1'b1;
                inflight_pc <= fetch_pc;
            end else begin
                inflight <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PtrW + 1)'(1);
                2'b01:   count <= count - (PtrW + 1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch_buf.sv
// Bench for ifetch_buf: directed scenarios plus randomized ready/redirect/reset, checked
// against a queue-based model of the buffer.
module tb_ifetch_buf;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rom_salt = 32'h0;
    int          total = 0;
    int          passed = 0;
    int          dut_issues = 0;

    // Model state: next fetch PC, the outstanding read, and the buffered {inst, pc} words.
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_ifpc = 32'h0;
    logic [31:0] m_ifinst = 32'h0;
    bit          m_if = 1'b0;
    logic [63:0] q[$];

    ifetch_buf_if bus ();

    ifetch_buf #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // ROM: word = address ^ salt, returned one cycle after the address is presented.
    always @(posedge clk) bus.rom_inst <= bus.rom_addr ^ rom_salt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cycle();
        logic        en_e;
        logic        v_e;
        logic [31:0] inst_e;
        logic [31:0] pc_e;
        @(negedge clk);
        en_e   = !rst && !bus.redirect_i && ((q.size() + int'(m_if)) < DEPTH);
        v_e    = (q.size() != 0);
        pc_e   = v_e ? q[0][31:0] : 32'h0;
        inst_e = v_e ? q[0][63:32] : 32'h0;
        check("rom_en", bus.rom_en, en_e);
        check("rom_addr", bus.rom_addr, m_pc);
        check("inst_valid", bus.inst_valid_o, v_e);
        check("inst", bus.inst_o, inst_e);
        check("inst_pc", bus.inst_pc_o, pc_e);
        if (bus.rom_en === 1'b1) dut_issues++;
        if (rst) begin
            q.delete();
            m_if = 1'b0;
            m_pc = RESET_PC;
        end else if (bus.redirect_i) begin
            q.delete();
            m_if = 1'b0;
            m_pc = {bus.redirect_pc_i[31:2], 2'b00};
        end else begin
            if (v_e && bus.inst_ready_i) void'(q.pop_front());
            if (m_if) q.push_back({m_ifinst, m_ifpc});
            if (en_e) begin
                m_ifpc   = m_pc;
                m_ifinst = m_pc ^ rom_salt;
                m_pc     = m_pc + 32'd4;
                m_if     = 1'b1;
            end else begin
                m_if = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst               = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.inst_ready_i  = 1'b1;
        repeat (3) cycle();

        // Streaming from reset release: first word valid two cycles after the first issue.
        rst = 1'b0;
        repeat (2) cycle();
        check("stream_first_valid", bus.inst_valid_o, 1'b1);
        check("stream_first_pc", bus.inst_pc_o, 32'h0);
        repeat (8) cycle();

        // Decode stalled: exactly DEPTH reads, head held, then drain in order.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.inst_ready_i = 1'b0;
        dut_issues = 0;
        repeat (8) cycle();
        check("stall_issues", dut_issues, 4);
        check("stall_head_pc", bus.inst_pc_o, 32'h0);
        bus.inst_ready_i = 1'b1;
        repeat (8) cycle();

        // Redirect with three buffered words and one read outstanding.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.inst_ready_i = 1'b0;
        repeat (4) cycle();
        bus.inst_ready_i  = 1'b1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0102;
        cycle();
        bus.redirect_i = 1'b0;
        check("redir_valid_drop", bus.inst_valid_o, 1'b0);
        check("redir_new_addr", bus.rom_addr, 32'h0000_0100);
        repeat (8) cycle();

        // Back-to-back redirects, the first alongside a valid pop.
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0340;
        cycle();
        bus.redirect_pc_i = 32'h0000_0200;
        cycle();
        bus.redirect_i = 1'b0;
        repeat (8) cycle();

        // Fetch PC wrap across 0xFFFF_FFFC.
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFF4;
        cycle();
        bus.redirect_i = 1'b0;
        repeat (8) cycle();

        // Random ready and redirects with a reset pulse mid-stream.
        for (int i = 0; i < 300; i++) begin
            bus.inst_ready_i  = 1'($urandom_range(0, 1));
            bus.redirect_i    = ($urandom_range(0, 19) == 0);
            bus.redirect_pc_i = $urandom;
            rst               = (i == 150 || i == 151);
            if (i == 150) rom_salt = $urandom;
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
